wash_run: RTL and testbench
===========================

// Module: wash_run
// PURPOSE
//  Execution back end of the washer: consumes the start/mode/balance handoff produced by the
//  settings front end. Charges the wash price against the balance, then sequences timed
//  WASH/RINSE/SPIN phases. Each phase counts down in BCD seconds for the seven-segment scanner.
//  Drives the phase lights and the done/error flags back to the top level.
// PARAMETERS
//  TICK     100_000_000  clk cycles per displayed second (bench uses 4)
//  T_WASH   20           wash phase length, seconds (heavy mode uses 2*T_WASH)
//  T_RINSE  10           rinse phase length, seconds
//  T_SPIN   5            spin phase length, seconds; every length must be 1..999
//  P_STD 10, P_QUICK 6, P_HEAVY 15, P_SPIN 3   price per mode, balance units
// PORTS
//  clk       in   1   system clock
//  rst       in   1   synchronous reset, active-high
//  start     in   1   1-cycle pulse: confirmed start (already gated by front end isOn)
//  mode      in   2   00 std, 01 quick, 10 heavy, 11 spin-only; sampled on start
//  bal_in    in   12  signed balance from front end; sampled in CHARGE
//  pause     in   1   1-cycle pulse, toggles pause while running
//  abort     in   1   1-cycle pulse, cancels run, no refund
//  bal_out   out  12  signed balance after charge
//  busy      out  1   1 in CHARGE and any phase state
//  done      out  1   1 in DONE
//  err       out  1   1 in ERR (insufficient balance)
//  paused    out  1   current pause flag
//  t2,t1,t0  out  4 each  BCD remaining seconds of current phase (hundreds, tens, units)
//  st_light  out  3   001 WASH, 010 RINSE, 100 SPIN, 111 DONE, 000 otherwise
// BEHAVIOUR
//  Reset (rst=1 at posedge): state IDLE; bal_out=0; busy=done=err=paused=0; t2..t0=0;
//   st_light=000; tick counter=0; latched mode=00. Reset mid-run discards everything.
//  States: IDLE, CHARGE, WASH, RINSE, SPIN, DONE, ERR.
//  Phase sequences:
//   std: WASH, RINSE, SPIN.
//   quick: WASH, SPIN.
//   heavy: WASH(2*T_WASH), RINSE, SPIN.
//   spin-only: SPIN.
//  IDLE: start=1 -> latch mode, go to CHARGE next cycle. pause and abort are ignored.
//  CHARGE (exactly 1 cycle): signed compare bal_in >= price(mode).
//   - True: bal_out <= bal_in - price, enter first phase.
//   - False: go to ERR; bal_out is unchanged.
//  Phase entry: {t2,t1,t0} <= BCD(duration); tick counter <= 0; paused <= 0.
//  In a phase with paused=0: the tick counter counts 0..TICK-1.
//   - At TICK-1, if remaining==001, advance to the next phase, or to DONE after the last one.
//   - Otherwise decrement the BCD value with borrow (e.g. 100 -> 099, 010 -> 009).
//   - A phase therefore lasts exactly duration*TICK cycles; t never shows 000 while busy.
//  paused=1: the tick counter and t are frozen. A pause pulse toggles paused (phase states only).
//  abort in CHARGE or any phase: next state IDLE, t=0, paused=0; bal_out keeps the charged value.
//  Simultaneous events:
//   - abort beats pause and expiry.
//   - pause arriving in the expiry cycle: the expiry completes, then the pause is cleared by
//     phase entry.
//  DONE: t=000, st_light=111, done held until the next start pulse (-> CHARGE directly).
//  ERR: err held until the next start pulse (-> CHARGE with the newly latched mode) or abort (-> IDLE).
//  All outputs are registered or decoded from registered state; no combinational path from inputs.
// TESTING (TICK=4, T_WASH=3, T_RINSE=2, T_SPIN=1)
//  1. rst high for 2 cycles -> all outputs 0, state IDLE; a pause pulse in IDLE leaves paused=0.
//  2. bal_in=20, mode=00, start -> bal_out=10 after CHARGE, t=003 WASH.
//     Then RINSE after 12 cycles, SPIN after 8, DONE after 4; st_light 001/010/100/111.
//  3. bal_in=5, mode=10, start -> err=1, bal_out unchanged.
//     Then abort -> IDLE, err=0.
//  4. mode=01, bal_in=6 -> bal_out=0, phases WASH then SPIN (no RINSE).
//     Second start from DONE with bal_in=0 -> ERR.
//  5. Pause pulse mid-WASH for 10 cycles -> t frozen. Second pause resumes, and the total WASH
//     length = 12 cycles + paused time.
//  6. Abort and pause in the same cycle during RINSE -> IDLE, paused=0, t=000.
//     rst asserted mid-SPIN -> reset values the next cycle.
//  Bench also checks the BCD borrow with T_WASH=100: 100 -> 099 -> 098.

Source files
------------

// File: rtl/wash_run.sv
// Washer execution back end. Charges the selected program against the balance,
// then sequences the timed WASH/RINSE/SPIN phases with a BCD seconds countdown.
// All outputs come straight from flops; none has a combinational path from an input.
module wash_run #(
  parameter int unsigned TICK    = 100_000_000,
  parameter int unsigned T_WASH  = 20,
  parameter int unsigned T_RINSE = 10,
  parameter int unsigned T_SPIN  = 5,
  parameter int unsigned P_STD   = 10,
  parameter int unsigned P_QUICK = 6,
  parameter int unsigned P_HEAVY = 15,
  parameter int unsigned P_SPIN  = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [1:0]  mode_i,
  input  logic [11:0] bal_in_i,
  input  logic        pause_i,
  input  logic        abort_i,
  output logic [11:0] bal_out_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic        paused_o,
  output logic [3:0]  t2_o,
  output logic [3:0]  t1_o,
  output logic [3:0]  t0_o,
  output logic [2:0]  st_light_o
);

  localparam int unsigned TW = (TICK > 32'd1) ? $clog2(TICK) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK - 32'd1);
  localparam logic [TW-1:0] TICK_ONE  = TW'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHARGE = 3'd1,
    S_WASH   = 3'd2,
    S_RINSE  = 3'd3,
    S_SPIN   = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  // Binary seconds to three BCD digits {hundreds, tens, units}.
  function automatic logic [11:0] to_bcd(input int unsigned v);
    to_bcd = {4'((v / 32'd100) % 32'd10), 4'((v / 32'd10) % 32'd10), 4'(v % 32'd10)};
  endfunction

  // BCD decrement with borrow; only used while the value is above 001.
  function automatic logic [11:0] bcd_dec(input logic [11:0] v);
    logic [3:0] h, t, u;
    h = v[11:8];
    t = v[7:4];
    u = v[3:0];
    if (u != 4'd0) begin
      u = u - 4'd1;
    end else begin
      u = 4'd9;
      if (t != 4'd0) begin
        t = t - 4'd1;
      end else begin
        t = 4'd9;
        h = h - 4'd1;
      end
    end
    bcd_dec = {h, t, u};
  endfunction

  // Program price in balance units.
  function automatic logic [11:0] price_of(input logic [1:0] m);
    case (m)
      2'b00:   price_of = 12'(P_STD);
      2'b01:   price_of = 12'(P_QUICK);
      2'b10:   price_of = 12'(P_HEAVY);
      2'b11:   price_of = 12'(P_SPIN);
      default: price_of = 12'(P_STD);
    endcase
  endfunction

  // First phase of a program: spin-only skips straight to SPIN.
  function automatic state_t first_phase(input logic [1:0] m);
    first_phase = (m == 2'b11) ? S_SPIN : S_WASH;
  endfunction

  // Phase following s; quick skips RINSE, SPIN is always last.
  function automatic state_t next_phase(input state_t s, input logic [1:0] m);
    case (s)
      S_WASH:  next_phase = (m == 2'b01) ? S_SPIN : S_RINSE;
      S_RINSE: next_phase = S_SPIN;
      S_SPIN:  next_phase = S_DONE;
      default: next_phase = S_IDLE;
    endcase
  endfunction

  // Phase length in BCD; heavy doubles the wash.
  function automatic logic [11:0] dur_bcd(input state_t s, input logic [1:0] m);
    case (s)
      S_WASH:  dur_bcd = (m == 2'b10) ? to_bcd(32'd2 * T_WASH) : to_bcd(T_WASH);
      S_RINSE: dur_bcd = to_bcd(T_RINSE);
      S_SPIN:  dur_bcd = to_bcd(T_SPIN);
      default: dur_bcd = 12'h000;
    endcase
  endfunction

  // Phase light pattern for a state.
  function automatic logic [2:0] light_of(input state_t s);
    case (s)
      S_WASH:  light_of = 3'b001;
      S_RINSE: light_of = 3'b010;
      S_SPIN:  light_of = 3'b100;
      S_DONE:  light_of = 3'b111;
      default: light_of = 3'b000;
    endcase
  endfunction

  state_t         state_q, state_d;
  logic [1:0]     mode_q, mode_d;
  logic [11:0]    bal_q, bal_d;
  logic [TW-1:0]  tick_q, tick_d;
  logic [11:0]    t_q, t_d;
  logic           paused_q, paused_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           err_q, err_d;
  logic [2:0]     light_q, light_d;
  state_t         nxt_s;

  // Next-state and next-output computation for the whole run sequencer.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    bal_d    = bal_q;
    tick_d   = tick_q;
    t_d      = t_q;
    paused_d = paused_q;
    nxt_s    = next_phase(state_q, mode_q);
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_CHARGE;
          mode_d  = mode_i;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CHARGE: begin
        if (abort_i) begin
          state_d  = S_IDLE;
          t_d      = 12'h000;
          paused_d = 1'b0;
        end else if ($signed(bal_in_i) >= $signed(price_of(mode_q))) begin
          bal_d    = bal_in_i - price_of(mode_q);
          state_d  = first_phase(mode_q);
          t_d      = dur_bcd(first_phase(mode_q), mode_q);
          tick_d   = '0;
          paused_d = 1'b0;
        end else begin
          state_d = S_ERR;
        end
      end
      S_WASH, S_RINSE, S_SPIN: begin
        if (abort_i) begin
          state_d  = S_IDLE;
          t_d      = 12'h000;
          tick_d   = '0;
          paused_d = 1'b0;
        end else if (paused_q) begin
          paused_d = ~pause_i;
        end else if (tick_q == TICK_LAST) begin
          tick_d = '0;
          if (t_q == 12'h001) begin
            // Expiry wins over a coincident pause: the new phase starts unpaused.
            paused_d = 1'b0;
            state_d  = nxt_s;
            if (nxt_s == S_DONE) begin
              t_d = 12'h000;
            end else begin
              t_d = dur_bcd(nxt_s, mode_q);
            end
          end else begin
            t_d      = bcd_dec(t_q);
            paused_d = pause_i;
          end
        end else begin
          tick_d   = tick_q + TICK_ONE;
          paused_d = pause_i;
        end
      end
      S_DONE: begin
        if (start_i) begin
          state_d = S_CHARGE;
          mode_d  = mode_i;
        end else begin
          state_d = S_DONE;
        end
      end
      S_ERR: begin
        if (start_i) begin
          state_d = S_CHARGE;
          mode_d  = mode_i;
        end else if (abort_i) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_ERR;
        end
      end
      default: begin
        state_d  = S_IDLE;
        t_d      = 12'h000;
        tick_d   = '0;
        paused_d = 1'b0;
      end
    endcase
    busy_d  = (state_d == S_CHARGE) || (state_d == S_WASH) ||
              (state_d == S_RINSE)  || (state_d == S_SPIN);
    done_d  = (state_d == S_DONE);
    err_d   = (state_d == S_ERR);
    light_d = light_of(state_d);
  end

  // Sequencer state and registered outputs, with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      mode_q   <= 2'b00;
      bal_q    <= 12'h000;
      tick_q   <= '0;
      t_q      <= 12'h000;
      paused_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      light_q  <= 3'b000;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      bal_q    <= bal_d;
      tick_q   <= tick_d;
      t_q      <= t_d;
      paused_q <= paused_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      light_q  <= light_d;
    end
  end

  assign bal_out_o  = bal_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign paused_o   = paused_q;
  assign t2_o       = t_q[11:8];
  assign t1_o       = t_q[7:4];
  assign t0_o       = t_q[3:0];
  assign st_light_o = light_q;

endmodule

// File: tb/tb_wash_run.sv
// Bench for wash_run: directed scenarios plus random programs/balances, checked
// against a program-level model (price table, phase list, remaining = D - c/TICK).
module tb_wash_run;

  localparam int TICK = 4;

  logic        clk = 1'b0;
  logic        rst, start, pause, abort;
  logic [1:0]  mode;
  logic [11:0] bal_in;
  logic [11:0] bal_out;
  logic        busy, done, err, paused;
  logic [3:0]  t2, t1, t0;
  logic [2:0]  light;

  logic        b_start, b_pause, b_abort;
  logic [1:0]  b_mode;
  logic [11:0] b_bal_in, b_bal_out;
  logic        b_busy, b_done, b_err, b_paused;
  logic [3:0]  b_t2, b_t1, b_t0;
  logic [2:0]  b_light;

  always #5 clk = ~clk;

  wash_run #(.TICK(4), .T_WASH(3), .T_RINSE(2), .T_SPIN(1)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .mode_i(mode), .bal_in_i(bal_in),
    .pause_i(pause), .abort_i(abort), .bal_out_o(bal_out), .busy_o(busy),
    .done_o(done), .err_o(err), .paused_o(paused), .t2_o(t2), .t1_o(t1),
    .t0_o(t0), .st_light_o(light)
  );

  wash_run #(.TICK(4), .T_WASH(100), .T_RINSE(2), .T_SPIN(1)) dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(b_start), .mode_i(b_mode), .bal_in_i(b_bal_in),
    .pause_i(b_pause), .abort_i(b_abort), .bal_out_o(b_bal_out), .busy_o(b_busy),
    .done_o(b_done), .err_o(b_err), .paused_o(b_paused), .t2_o(b_t2), .t1_o(b_t1),
    .t0_o(b_t0), .st_light_o(b_light)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  int          plan_n;
  int          plan_dur [3];
  logic [2:0]  plan_lt  [3];
  logic [11:0] exp_bal;
  logic        last_err;
  int          wash_cycles;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tk();
    @(posedge clk);
    #1;
  endtask

  function automatic int price(input logic [1:0] m);
    case (m)
      2'b00:   return 10;
      2'b01:   return 6;
      2'b10:   return 15;
      default: return 3;
    endcase
  endfunction

  task automatic make_plan(input logic [1:0] m);
    case (m)
      2'b00: begin plan_n = 3; plan_dur = '{3, 2, 1}; plan_lt = '{3'b001, 3'b010, 3'b100}; end
      2'b01: begin plan_n = 2; plan_dur = '{3, 1, 0}; plan_lt = '{3'b001, 3'b100, 3'b000}; end
      2'b10: begin plan_n = 3; plan_dur = '{6, 2, 1}; plan_lt = '{3'b001, 3'b010, 3'b100}; end
      default: begin plan_n = 1; plan_dur = '{1, 0, 0}; plan_lt = '{3'b100, 3'b000, 3'b000}; end
    endcase
  endtask

  function automatic logic [11:0] bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic do_start(input logic [1:0] m, input logic [11:0] b);
    mode   = m;
    bal_in = b;
    start  = 1'b1;
    tk();
    start  = 1'b0;
    chk("charge_busy", 32'(busy), 32'd1);
    chk("charge_light", 32'(light), 32'd0);
  endtask

  task automatic do_abort();
    abort = 1'b1;
    tk();
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_err", 32'(err), 32'd0);
    chk("abort_bal", 32'(bal_out), 32'(exp_bal));
  endtask

  // Full program: charge, then every phase cycle by cycle, then DONE or ERR.
  task automatic run_job(input logic [1:0] m, input logic signed [11:0] b);
    do_start(m, b);
    tk();
    if (int'(b) >= price(m)) begin
      last_err = 1'b0;
      exp_bal  = b - 12'(price(m));
      chk("charged_bal", 32'(bal_out), 32'(exp_bal));
      make_plan(m);
      for (int p = 0; p < plan_n; p++) begin
        for (int c = 0; c < plan_dur[p] * TICK; c++) begin
          chk("phase_light", 32'(light), 32'(plan_lt[p]));
          chk("phase_t", 32'({t2, t1, t0}), 32'(bcd(plan_dur[p] - c / TICK)));
          chk("phase_busy", 32'(busy), 32'd1);
          tk();
        end
      end
      chk("done_flag", 32'(done), 32'd1);
      chk("done_light", 32'(light), 32'd7);
      chk("done_t", 32'({t2, t1, t0}), 32'd0);
      chk("done_busy", 32'(busy), 32'd0);
    end else begin
      last_err = 1'b1;
      chk("err_flag", 32'(err), 32'd1);
      chk("err_bal", 32'(bal_out), 32'(exp_bal));
      chk("err_busy", 32'(busy), 32'd0);
      chk("err_light", 32'(light), 32'd0);
    end
  endtask

  task automatic chk_reset();
    chk("rst_bal", 32'(bal_out), 32'd0);
    chk("rst_flags", 32'({busy, done, err, paused}), 32'd0);
    chk("rst_t", 32'({t2, t1, t0}), 32'd0);
    chk("rst_light", 32'(light), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pause = 1'b0; abort = 1'b0; mode = 2'b00; bal_in = 12'd0;
    b_start = 1'b0; b_pause = 1'b0; b_abort = 1'b0; b_mode = 2'b00; b_bal_in = 12'd20;
    exp_bal = 12'd0; last_err = 1'b0;
    tk(); tk();
    chk_reset();
    rst = 1'b0;
    pause = 1'b1; tk(); pause = 1'b0;
    chk("idle_pause", 32'(paused), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);

    // BCD borrow across hundreds/tens on the long-wash instance.
    b_start = 1'b1; tk(); b_start = 1'b0; tk();
    chk("bcd_100", 32'({b_t2, b_t1, b_t0}), 32'h100);
    repeat (4) tk();
    chk("bcd_099", 32'({b_t2, b_t1, b_t0}), 32'h099);
    repeat (4) tk();
    chk("bcd_098", 32'({b_t2, b_t1, b_t0}), 32'h098);
    chk("bcd_light", 32'(b_light), 32'd1);

    // Standard, then heavy with too little balance, then quick to zero.
    run_job(2'b00, 12'sd20);
    run_job(2'b10, 12'sd5);
    do_abort();
    run_job(2'b01, 12'sd6);
    run_job(2'b00, 12'sd0);
    do_abort();

    // Pause for 11 frozen cycles mid-WASH; WASH should last 12 + 11 cycles.
    do_start(2'b00, 12'sd50);
    tk();
    exp_bal = 12'd40;
    chk("pause_bal", 32'(bal_out), 32'(exp_bal));
    wash_cycles = 0;
    repeat (5) begin wash_cycles++; tk(); end
    wash_cycles++;
    pause = 1'b1; tk(); pause = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("pause_flag", 32'(paused), 32'd1);
      chk("pause_t", 32'({t2, t1, t0}), 32'h002);
      wash_cycles++;
      tk();
    end
    wash_cycles++;
    pause = 1'b1; tk(); pause = 1'b0;
    chk("resume_flag", 32'(paused), 32'd0);
    for (int i = 0; i < 40; i++) begin
      if (light != 3'b001) break;
      wash_cycles++;
      tk();
    end
    chk("pause_wash_len", 32'(wash_cycles), 32'd23);
    chk("pause_rinse", 32'(light), 32'd2);
    repeat (12) tk();
    chk("pause_done", 32'(done), 32'd1);

    // Abort together with pause during RINSE.
    do_start(2'b00, 12'sd40);
    tk();
    exp_bal = 12'd30;
    repeat (12) tk();
    chk("ab_rinse", 32'(light), 32'd2);
    tk(); tk();
    pause = 1'b1; abort = 1'b1; tk(); pause = 1'b0; abort = 1'b0;
    chk("ab_busy", 32'(busy), 32'd0);
    chk("ab_paused", 32'(paused), 32'd0);
    chk("ab_t", 32'({t2, t1, t0}), 32'd0);
    chk("ab_light", 32'(light), 32'd0);
    chk("ab_bal", 32'(bal_out), 32'(exp_bal));

    // Reset asserted during SPIN.
    do_start(2'b00, 12'sd40);
    tk();
    repeat (20) tk();
    chk("rst_spin_light", 32'(light), 32'd4);
    rst = 1'b1; tk(); rst = 1'b0;
    chk_reset();
    exp_bal = 12'd0;

    // Random programs and balances, including negative balances.
    for (int i = 0; i < 10; i++) begin
      logic [1:0]  rm;
      logic [11:0] rb;
      rm = 2'($urandom_range(0, 3));
      rb = 12'($urandom_range(0, 40)) - 12'd10;
      run_job(rm, rb);
      if (last_err) do_abort();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
